// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the retro16 memory path: arbiter states, default
// bus widths and the I/O window base used by the bus decoder.
`timescale 1ns/1ps
package retro16_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    // Start of the memory-mapped I/O window; addresses at or above it are I/O.
    localparam logic [15:0] MEM_IO_BASE = 16'hC000;

    function automatic logic is_io_addr(input logic [15:0] addr);
        return (addr >= MEM_IO_BASE);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the memory controller port.
// slave = arbiter view, master = requesters plus controller (bench side).
`timescale 1ns/1ps
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_read_en;
    logic              mem_write_en;
    logic [DATA_W-1:0] mem_data_out;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rdata, busy,
        output mem_address, mem_data_in, mem_read_en, mem_write_en,
        input  mem_data_out
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata, busy,
        input  mem_address, mem_data_in, mem_read_en, mem_write_en,
        output mem_data_out
    );
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone request wins outright, on contention the
// requester that was not granted last wins.
`timescale 1ns/1ps
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       gnt_valid_o,
    output logic       gnt_idx_o
);
    // Pure combinational choice from the request pair and the previous winner.
    always_comb begin
        gnt_valid_o = |req_i;
        gnt_idx_o   = 1'b0;
        if (req_i == 2'b11) begin
            gnt_idx_o = ~last_grant_i;
        end else if (req_i == 2'b10) begin
            gnt_idx_o = 1'b1;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory controller port between the CPU bus (0) and
// DMA / boot loader (1). Each access is a fixed-length enable burst followed
// by one idle DONE cycle that resets the controller's byte phase.
`timescale 1ns/1ps
module mem_arbiter
    import retro16_mem_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int ACCESS_CYCLES = 3
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);
    // The burst counter is 4 bits wide, which bounds the legal burst length.
    if (ACCESS_CYCLES < 2 || ACCESS_CYCLES > 15) begin : g_bad_cfg
        $error("mem_arbiter: ACCESS_CYCLES must be within 2..15");
    end

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              we_q;
    logic              gidx_q;
    logic              last_grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rd_en_q;
    logic              wr_en_q;
    logic              ack0_q;
    logic              ack1_q;
    logic              busy_q;

    logic              gnt_valid_d;
    logic              gnt_idx_d;
    logic              sel_we_d;
    logic [ADDR_W-1:0] sel_addr_d;
    logic [DATA_W-1:0] sel_wdata_d;

    rr_pick2 u_pick (
        .req_i        ({bus.req1, bus.req0}),
        .last_grant_i (last_grant_q),
        .gnt_valid_o  (gnt_valid_d),
        .gnt_idx_o    (gnt_idx_d)
    );

    // Route the winning requester's command fields toward the latch.
    always_comb begin
        sel_we_d    = gnt_idx_d ? bus.we1    : bus.we0;
        sel_addr_d  = gnt_idx_d ? bus.addr1  : bus.addr0;
        sel_wdata_d = gnt_idx_d ? bus.wdata1 : bus.wdata0;
    end

    // Arbiter FSM with all outputs registered; reset abandons any access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            gidx_q       <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_valid_d) begin
                        gidx_q  <= gnt_idx_d;
                        we_q    <= sel_we_d;
                        addr_q  <= sel_addr_d;
                        wdata_q <= sel_wdata_d;
                        cnt_q   <= CNT_LOAD;
                        rd_en_q <= ~sel_we_d;
                        wr_en_q <= sel_we_d;
                        busy_q  <= 1'b1;
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        rd_en_q <= 1'b0;
                        wr_en_q <= 1'b0;
                        if (!we_q) begin
                            rdata_q <= bus.mem_data_out;
                        end
                        ack0_q  <= ~gidx_q;
                        ack1_q  <= gidx_q;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_DONE: begin
                    last_grant_q <= gidx_q;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_address  = addr_q;
    assign bus.mem_data_in  = wdata_q;
    assign bus.mem_read_en  = rd_en_q;
    assign bus.mem_write_en = wr_en_q;
    assign bus.rdata        = rdata_q;
    assign bus.ack0         = ack0_q;
    assign bus.ack1         = ack1_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 3-cycle instance exercised through single
// reads/writes, contention and mid-access reset, plus a 2-cycle instance.
`timescale 1ns/1ps
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus  ();
    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus2 ();

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .ACCESS_CYCLES(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .ACCESS_CYCLES(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // Controller model: fixed pattern at 0x0200, address-derived data elsewhere.
    function automatic logic [15:0] mem_model(input logic [15:0] a);
        return (a == 16'h0200) ? 16'hBEEF : (a ^ 16'h5A5A);
    endfunction

    assign bus.mem_data_out  = mem_model(bus.mem_address);
    assign bus2.mem_data_out = mem_model(bus2.mem_address);

    // Per-cycle activity on the 3-cycle instance, sampled mid-cycle.
    int          rd_hi = 0, wr_hi = 0, ack0_n = 0, ack1_n = 0;
    int          viol_n = 0, bursts = 0, wbad_n = 0;
    logic        en_prev = 1'b0;
    logic [15:0] exp_waddr = 16'h0, exp_wdata = 16'h0;

    always @(negedge clk) begin
        if (bus.mem_read_en)  rd_hi++;
        if (bus.mem_write_en) wr_hi++;
        if (bus.ack0) ack0_n++;
        if (bus.ack1) ack1_n++;
        if (bus.mem_read_en && bus.mem_write_en) viol_n++;
        if ((bus.ack0 || bus.ack1) && (bus.mem_read_en || bus.mem_write_en)) viol_n++;
        if (bus.ack0 && bus.ack1) viol_n++;
        if ((bus.mem_read_en || bus.mem_write_en) && !en_prev) bursts++;
        en_prev = bus.mem_read_en || bus.mem_write_en;
        if (bus.mem_write_en && (bus.mem_address != exp_waddr || bus.mem_data_in != exp_wdata))
            wbad_n++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one access on the 3-cycle instance; lat = ticks until ack, -1 on timeout.
    task automatic run1(input bit idx, input bit we, input logic [15:0] a,
                        input logic [15:0] d, output int lat);
        if (idx) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (idx ? bus.ack1 : bus.ack0) begin
                lat = i;
                break;
            end
        end
        if (idx) bus.req1 = 1'b0;
        else     bus.req0 = 1'b0;
    endtask

    int   lat, n_ack, en_cnt;
    int   b_rd, b_wr, b_a0, b_a1, b_v, b_bu, b_wb;
    int   when_q [4];
    logic [3:0] order;
    logic [1:0] first;

    initial begin
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
        bus2.req0 = 0; bus2.req1 = 0; bus2.we0 = 0; bus2.we1 = 0;
        bus2.addr0 = 0; bus2.addr1 = 0; bus2.wdata0 = 0; bus2.wdata1 = 0;
        order = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_en",    32'({bus.mem_read_en, bus.mem_write_en}), 32'd0);
        chk("rst_ack",   32'({bus.ack0, bus.ack1}), 32'd0);
        chk("rst_addr",  32'(bus.mem_address), 32'd0);
        chk("rst_wdata", 32'(bus.mem_data_in), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);

        // Single read by requester 0.
        b_rd = rd_hi; b_wr = wr_hi; b_a0 = ack0_n; b_a1 = ack1_n;
        run1(1'b0, 1'b0, 16'h0200, 16'h0000, lat);
        chk("rd_lat",       32'(lat), 32'd4);
        chk("rd_busy_done", 32'(bus.busy), 32'd1);
        chk("rd_data",      32'(bus.rdata), 32'hBEEF);
        tick();
        chk("rd_busy_idle", 32'(bus.busy), 32'd0);
        tick();
        chk("rd_en_cycles", 32'(rd_hi - b_rd), 32'd3);
        chk("rd_no_wr",     32'(wr_hi - b_wr), 32'd0);
        chk("rd_ack0_once", 32'(ack0_n - b_a0), 32'd1);
        chk("rd_no_ack1",   32'(ack1_n - b_a1), 32'd0);

        // Single write by requester 1.
        exp_waddr = 16'h1234; exp_wdata = 16'hA55A;
        b_rd = rd_hi; b_wr = wr_hi; b_a0 = ack0_n; b_a1 = ack1_n; b_wb = wbad_n;
        run1(1'b1, 1'b1, 16'h1234, 16'hA55A, lat);
        chk("wr_lat", 32'(lat), 32'd4);
        tick(); tick();
        chk("wr_en_cycles", 32'(wr_hi - b_wr), 32'd3);
        chk("wr_no_rd",     32'(rd_hi - b_rd), 32'd0);
        chk("wr_bus_stable",32'(wbad_n - b_wb), 32'd0);
        chk("wr_ack1_once", 32'(ack1_n - b_a1), 32'd1);
        chk("wr_no_ack0",   32'(ack0_n - b_a0), 32'd0);
        chk("wr_rdata_kept",32'(bus.rdata), 32'hBEEF);

        // Contention: both held for four accesses.
        exp_waddr = 16'h0020; exp_wdata = 16'h1111;
        b_rd = rd_hi; b_wr = wr_hi; b_v = viol_n; b_bu = bursts; b_wb = wbad_n;
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0010;
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 16'h0020; bus.wdata1 = 16'h1111;
        n_ack = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.ack0 || bus.ack1) begin
                order[3 - n_ack] = bus.ack1;
                when_q[n_ack] = i;
                n_ack++;
                if (n_ack == 4) break;
            end
        end
        bus.req0 = 0; bus.req1 = 0;
        chk("cont_acks",  32'(n_ack), 32'd4);
        chk("cont_order", 32'(order), 32'b0101);
        chk("cont_first", 32'(when_q[0]), 32'd4);
        chk("cont_gap1",  32'(when_q[1] - when_q[0]), 32'd5);
        chk("cont_gap2",  32'(when_q[2] - when_q[1]), 32'd5);
        chk("cont_gap3",  32'(when_q[3] - when_q[2]), 32'd5);
        tick(); tick(); tick();
        chk("cont_bursts",  32'(bursts - b_bu), 32'd4);
        chk("cont_viol",    32'(viol_n - b_v), 32'd0);
        chk("cont_rd_cyc",  32'(rd_hi - b_rd), 32'd6);
        chk("cont_wr_cyc",  32'(wr_hi - b_wr), 32'd6);
        chk("cont_wr_bus",  32'(wbad_n - b_wb), 32'd0);
        chk("cont_rdata",   32'(bus.rdata), 32'h5A4A);

        // Reset in the second ACCESS cycle of a requester-1 read.
        b_a1 = ack1_n;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'h0300;
        tick(); tick();
        chk("mid_en_before", 32'(bus.mem_read_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_en",    32'({bus.mem_read_en, bus.mem_write_en}), 32'd0);
        chk("arst_ack",   32'({bus.ack0, bus.ack1}), 32'd0);
        chk("arst_busy",  32'(bus.busy), 32'd0);
        chk("arst_addr",  32'(bus.mem_address), 32'd0);
        chk("arst_rdata", 32'(bus.rdata), 32'd0);
        bus.req1 = 0;
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("arst_idle",   32'(bus.busy), 32'd0);
        chk("arst_no_ack", 32'(ack1_n - b_a1), 32'd0);
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0040;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'h0050;
        lat = -1; first = 2'b00;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.ack0 || bus.ack1) begin
                first = {bus.ack0, bus.ack1};
                lat = i;
                break;
            end
        end
        bus.req0 = 0; bus.req1 = 0;
        chk("arst_winner", 32'(first), 32'b10);
        chk("arst_lat",    32'(lat), 32'd4);
        tick(); tick();

        // Two-cycle build: read by requester 0.
        bus2.req0 = 1; bus2.we0 = 0; bus2.addr0 = 16'h0200;
        lat = -1; en_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus2.mem_read_en) en_cnt++;
            if (bus2.ack0) begin
                lat = i;
                break;
            end
        end
        bus2.req0 = 0;
        chk("ac2_en_cycles", 32'(en_cnt), 32'd2);
        chk("ac2_lat",       32'(lat), 32'd3);
        chk("ac2_rdata",     32'(bus2.rdata), 32'hBEEF);
        chk("ac2_no_wr",     32'(bus2.mem_write_en), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares the single `memory_controller` port between two requesters: requester 0 is the CPU bus, requester 1 is DMA / boot loader.
- Uses round-robin grant.
- Sequences each access as a fixed-length burst of `read_en`/`write_en` followed by a mandatory deassert cycle. That cycle resets the controller's byte phase.
- Returns read data and a one-cycle ack to the granted requester.

## Interface
Parameters:
- `ADDR_W`, 16: address width.
- `DATA_W`, 16: data width.
- `ACCESS_CYCLES`, 3: cycles `mem_read_en`/`mem_write_en` are held per access. Legal range 2..15.

Ports (reset is asynchronous and active-high):
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0`, `req1` in 1: access request; held high with address/data stable until ack.
- `we0`, `we1` in 1: 1 = write, 0 = read; valid with req.
- `addr0`, `addr1` in `ADDR_W`: word address.
- `wdata0`, `wdata1` in `DATA_W`: write data.
- `ack0`, `ack1` out 1: one-cycle completion pulse.
- `rdata` out `DATA_W`: read data, shared by both requesters; valid in the ack cycle of a read.
- `busy` out 1: high in any state other than IDLE.
- `mem_address` out `ADDR_W`: to controller `address_in`.
- `mem_data_in` out `DATA_W`: to controller `data_in`.
- `mem_read_en` out 1: to controller `read_en`.
- `mem_write_en` out 1: to controller `write_en`.
- `mem_data_out` in `DATA_W`: from controller `data_out`.

## Operation
States: IDLE, ACCESS, DONE.

**IDLE**
- Enables low.
- Samples `req0`/`req1`.
- One request: grant it. Both: grant the requester not granted last (`last_grant`).
- On grant: latch addr, wdata, we and the grant index; load `cnt` = `ACCESS_CYCLES-1`; go to ACCESS.
- No request: stay in IDLE.

**ACCESS**
- Drives the latched `mem_address`/`mem_data_in`.
- Asserts exactly one of `mem_read_en` (we=0) or `mem_write_en` (we=1).
- Decrements `cnt`; when `cnt`==0, go to DONE.

**DONE**
- Both enables low; this is the controller's byte-phase reset cycle.
- Read: `rdata` <= `mem_data_out` at the entry edge, so it is valid throughout DONE.
- Raises the ack of the granted requester for this cycle only.
- Updates `last_grant`; returns to IDLE.

Rules:
- `mem_address` and `mem_data_in` are held at their last values outside ACCESS.
- `rdata` holds its value until the next read completes. Writes do not change `rdata`.
- A requester must drop req in the cycle after its ack unless it intends a new access. The IDLE cycle after DONE samples req normally.
- Requests arriving during ACCESS/DONE wait; no request is lost or reordered.
- The arbiter never asserts `mem_read_en` and `mem_write_en` together, never asserts either outside ACCESS, and never asserts an ack outside DONE.

Reset (asynchronous, any time including mid-ACCESS):
- Control outputs: state=IDLE; enables=0, `ack0`=`ack1`=0, `busy`=0.
- Datapath registers: `mem_address`=0, `mem_data_in`=0, `rdata`=0.
- Arbitration state: `last_grant`=1, so requester 0 wins the first contention.
- Any in-flight access is abandoned with no ack; the requester must re-request.

## Timing
- All outputs are registered.
- Request high at edge E (state IDLE): enables high for edges E+1 .. E+`ACCESS_CYCLES`; ack high in cycle E+`ACCESS_CYCLES`+1.
- Minimum period per access: `ACCESS_CYCLES`+2 cycles (IDLE, ACCESS×N, DONE).
- Back-to-back contention alternates grants, e.g. 0,1,0,1 with both requests held.
- `busy` rises the cycle after grant and falls on the return to IDLE.

## Structure
- Shared package `retro16_mem_pkg`: state enum (IDLE/ACCESS/DONE), `ADDR_W`/`DATA_W` defaults, `MEM_IO_BASE`=16'hC000 constant reused by bus decode.
- One natural sub-module: `rr_pick2`, a two-way round-robin picker taking `req[1:0]` and `last_grant` and returning `gnt_valid` and `gnt_idx`. Combinational, instantiated once.

## Test plan
- Single read, req0, addr 0x0200, controller model returns 0xBEEF: `mem_read_en` high exactly 3 cycles; `ack0` on cycle 4 after sample; `rdata`=0xBEEF; `ack1` never.
- Single write, req1, addr 0x1234, wdata 0xA55A: `mem_write_en` high 3 cycles with `mem_address`=0x1234 and `mem_data_in`=0xA55A stable; `ack1` pulse; `rdata` unchanged.
- Both requests held for 4 accesses: grant order 0,1,0,1; each access 5 cycles apart; read and write enables never overlap.
- Reset asserted in the 2nd ACCESS cycle: all enables/acks low immediately (async); after release, state IDLE; requester 0 wins contention with 1.
- Enable gap: for every transaction, at least one cycle with both enables low between consecutive ACCESS bursts.
- `ACCESS_CYCLES`=2 rebuild: enable held 2 cycles; ack on cycle 3 after sample.
